hum_frame_rx: RTL and testbench



---
 rtl/hum_pkg.sv | 25 ++
 rtl/hum_frame_rx_dq_sync.sv | 41 ++++
 rtl/hum_frame_rx.sv | 136 +++++++++++++
 tb/tb_hum_frame_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hum_pkg.sv
// Shared types and constants for the humidity sensor frame receiver.
package hum_pkg;

  localparam int FRAME_BITS   = 40;
  localparam int SAMPLE_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    REL_WAIT,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } hum_rx_state_t;

  // The low byte carries the 8-bit sum of the four payload bytes.
  function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/hum_frame_rx_dq_sync.sv
// Two-flop synchronizer for the sensor line with registered edge strobes.
// Strobes are aligned with the second sync stage, so edges arrive 2 cycles late.
module dq_sync (
  input  logic clk,
  input  logic reset,
  input  logic dq_in,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync1_d = dq_in;
    sync2_d = sync1_q;
    rise_d  = ~sync2_q & sync1_q;
    fall_d  = sync2_q & ~sync1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;  // idle line is pulled high
      sync2_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/hum_frame_rx.sv
// Single-wire humidity/temperature sensor front end: start pulse, response and
// 40-bit decode, checksum verification and one FIFO write per valid frame.
module hum_frame_rx
  import hum_pkg::*;
#(
  parameter int CNT_WIDTH      = 15,
  parameter int START_CYCLES   = 18000,
  parameter int BIT_THRESH     = 40,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    dq_in,
  output logic                    dq_oe,
  input  logic                    fifo_full,
  output logic                    wr_en,
  output logic [SAMPLE_WIDTH-1:0] data_out,
  output logic                    busy,
  output logic                    done,
  output logic                    crc_err,
  output logic                    timeout_err,
  output logic                    ovf_err
);

  localparam int IDX_WIDTH = $clog2(FRAME_BITS);
  localparam logic [CNT_WIDTH-1:0] START_LAST  = CNT_WIDTH'(START_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_ONE_MIN = CNT_WIDTH'(BIT_THRESH);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [IDX_WIDTH-1:0] LAST_BIT    = IDX_WIDTH'(FRAME_BITS - 1);

  hum_rx_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]  bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;

  logic dq_rise, dq_fall;
  logic sensor_phase, timeout_hit, crc_ok;

  dq_sync u_dq_sync (
    .clk   (clk),
    .reset (reset),
    .dq_in (dq_in),
    .rise  (dq_rise),
    .fall  (dq_fall)
  );

  assign sensor_phase = state_q inside {REL_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};
  assign timeout_hit  = sensor_phase && (cnt_q >= TIMEOUT_CNT);
  assign crc_ok       = checksum_ok(shreg_q);

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    dq_oe       = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    crc_err     = 1'b0;
    timeout_err = 1'b0;
    ovf_err     = 1'b0;

    if (timeout_hit) begin
      state_d     = IDLE;
      done        = 1'b1;
      timeout_err = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = START_LOW;
            bit_idx_d = '0;
          end
        end
        START_LOW: begin
          dq_oe = 1'b1;
          if (cnt_q == START_LAST) state_d = REL_WAIT;
        end
        REL_WAIT:  if (dq_fall) state_d = RESP_LOW;
        RESP_LOW:  if (dq_rise) state_d = RESP_HIGH;
        RESP_HIGH: if (dq_fall) state_d = BIT_LOW;
        BIT_LOW:   if (dq_rise) state_d = BIT_HIGH;
        BIT_HIGH: begin
          if (dq_fall) begin
            // cnt_q + 1 cycles have been spent high, so > BIT_THRESH means cnt_q >= BIT_THRESH
            shreg_d   = {shreg_q[FRAME_BITS-2:0], cnt_q >= BIT_ONE_MIN};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_BIT) state_d = CHECK;
            else                       state_d = BIT_LOW;
          end
        end
        CHECK: begin
          state_d = IDLE;
          done    = 1'b1;
          if (!crc_ok)        crc_err = 1'b1;
          else if (fifo_full) ovf_err = 1'b1;
          else                wr_en   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Reset aborts at once: the pad is released and no frame end is reported.
    if (reset) begin
      dq_oe       = 1'b0;
      wr_en       = 1'b0;
      done        = 1'b0;
      crc_err     = 1'b0;
      timeout_err = 1'b0;
      ovf_err     = 1'b0;
    end

    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    else                                       cnt_d = cnt_q + 1'b1;
  end

  // NOTE: the shift register is ordinary flops, so it takes the reset like the rest of the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign data_out = shreg_q[FRAME_BITS-1 -: SAMPLE_WIDTH];

endmodule

// File: tb/tb_hum_frame_rx.sv
// Directed bench for hum_frame_rx: a sensor model drives frames and a
// scoreboard queue holds the expected frame-end outcome of each request.
module tb_hum_frame_rx;

  localparam int START_TB   = 1800;
  localparam int TIMEOUT_TB = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dq_in = 1'b1;
  logic        fifo_full = 1'b0;
  logic        dq_oe, wr_en, busy, done, crc_err, timeout_err, ovf_err;
  logic [31:0] data_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        crc;
    logic        tmo;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t tmo_e;

  always #5 clk = ~clk;

  hum_frame_rx #(
    .START_CYCLES   (START_TB),
    .TIMEOUT_CYCLES (TIMEOUT_TB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dq_in       (dq_in),
    .dq_oe       (dq_oe),
    .fifo_full   (fifo_full),
    .wr_en       (wr_en),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .crc_err     (crc_err),
    .timeout_err (timeout_err),
    .ovf_err     (ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t frame_expect(input logic [39:0] f, input logic full_at_check);
    exp_t       e;
    logic [7:0] s;
    s      = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    e.data = f[39:8];
    e.crc  = (s != f[7:0]);
    e.tmo  = 1'b0;
    e.ovf  = !e.crc && full_at_check;
    e.wr   = !e.crc && !full_at_check;
    return e;
  endfunction

  // Scoreboard: every frame end is compared against the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_en", 32'(wr_en), 32'(mon_e.wr));
        if (mon_e.wr) check("data_out", data_out, mon_e.data);
        check("crc_err", 32'(crc_err), 32'(mon_e.crc));
        check("timeout_err", 32'(timeout_err), 32'(mon_e.tmo));
        check("ovf_err", 32'(ovf_err), 32'(mon_e.ovf));
      end
    end else begin
      if (wr_en !== 1'b0) check("wr_en_without_done", 32'(wr_en), 32'd0);
      if ({crc_err, timeout_err, ovf_err} !== 3'b000)
        check("flag_without_done", 32'({crc_err, timeout_err, ovf_err}), 32'd0);
    end
  end

  task automatic drive(input logic lvl, input int n);
    dq_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "dq_oe"}, 32'(dq_oe), 32'd0);
    check({pfx, "wr_en"}, 32'(wr_en), 32'd0);
    check({pfx, "data_out"}, data_out, 32'd0);
    check({pfx, "busy"}, 32'(busy), 32'd0);
    check({pfx, "done"}, 32'(done), 32'd0);
    check({pfx, "crc_err"}, 32'(crc_err), 32'd0);
    check({pfx, "timeout_err"}, 32'(timeout_err), 32'd0);
    check({pfx, "ovf_err"}, 32'(ovf_err), 32'd0);
  endtask

  task automatic run_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_dq_oe_after_start"}, 32'(dq_oe), 32'd1);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
  endtask

  // Counts the cycles dq_oe stays high; returns at the first cycle of REL_WAIT.
  task automatic measure_start(output int w);
    w = 1;
    while (dq_oe === 1'b1 && w < START_TB + 100) begin
      @(negedge clk);
      if (dq_oe === 1'b1) w++;
    end
  endtask

  // Sensor side of a frame; returns right after driving the final low.
  task automatic sensor_frame(input logic [39:0] f, input int h0, input int h1, input int abort_at);
    start = 1'b1;  // a request while busy must be ignored
    @(negedge clk);
    start = 1'b0;
    drive(1'b1, 9);
    drive(1'b0, 80);
    drive(1'b1, 80);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 30);
      if (i == abort_at) begin
        drive(1'b1, 10);
        return;
      end
      drive(1'b1, f[39-i] ? h1 : h0);
    end
    dq_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic finish_frame(input string tag);
    wait_done(tag);
    dq_in = 1'b1;
    @(negedge clk);
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    int k;
    logic [39:0] f1, f2, f4, f5, f7;
    f1 = 40'h35_00_18_00_4D;
    f2 = 40'h35_00_18_00_4E;
    f4 = 40'h3C_05_1A_03_5E;
    f5 = 40'hFF_80_90_01_10;
    f7 = 40'h41_09_17_02_63;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal frame; 40-cycle highs must decode as 0 and 41-cycle highs as 1.
    exp_q.push_back(frame_expect(f1, 1'b0));
    run_start("nominal");
    measure_start(w);
    check("start_pulse_cycles", 32'(w), 32'(START_TB));
    sensor_frame(f1, 40, 41, -1);
    finish_frame("nominal");
    repeat (5) @(negedge clk);
    check("start_not_queued", 32'(busy), 32'd0);

    exp_q.push_back(frame_expect(f2, 1'b0));
    run_start("crc");
    measure_start(w);
    sensor_frame(f2, 20, 60, -1);
    finish_frame("crc");

    // Sensor never answers after release.
    tmo_e = '{wr: 1'b0, data: 32'h0, crc: 1'b0, tmo: 1'b1, ovf: 1'b0};
    exp_q.push_back(tmo_e);
    run_start("timeout");
    measure_start(w);
    k = 0;
    while (done !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", 32'(k), 32'(TIMEOUT_TB));
    @(negedge clk);
    check("timeout_busy_after_done", 32'(busy), 32'd0);

    fifo_full = 1'b1;
    exp_q.push_back(frame_expect(f4, 1'b1));
    run_start("ovf");
    measure_start(w);
    sensor_frame(f4, 20, 60, -1);
    finish_frame("ovf");

    // fifo_full high during the bits but low by CHECK: the write goes through.
    exp_q.push_back(frame_expect(f5, 1'b0));
    run_start("after_ovf");
    measure_start(w);
    sensor_frame(f5, 20, 60, -1);
    fifo_full = 1'b0;
    finish_frame("after_ovf");

    // Reset while the high half of bit 20 is being timed.
    run_start("abort");
    measure_start(w);
    sensor_frame(f1, 20, 60, 20);
    check("abort_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort_");
    reset = 1'b0;

    // Reset during the start pulse releases the pad without waiting for an edge.
    run_start("startlow_reset");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_releases_dq_oe", 32'(dq_oe), 32'd0);
    @(negedge clk);
    check_reset_outputs("startlow_reset_");
    reset = 1'b0;

    exp_q.push_back(frame_expect(f7, 1'b0));
    run_start("clean");
    measure_start(w);
    sensor_frame(f7, 20, 60, -1);
    finish_frame("clean");

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
